// File: rtl/fx_sample_sequencer.sv
// Per-sample sequencer: input FIFO -> effect core -> output FIFO, with a bounded wait for the core.
// The output path never stalls; a full output FIFO drops the result. Statistics counters saturate.
module fx_sample_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk_500,
  input  logic              reset,
  input  logic              enable,
  input  logic              clr_stats,
  input  logic              in_rdempty,
  input  logic [DATA_W-1:0] in_q,
  output logic              in_rdreq,
  output logic [DATA_W-1:0] fx_sample,
  output logic              fx_valid,
  input  logic              fx_done,
  input  logic [DATA_W-1:0] fx_out,
  input  logic              out_wrfull,
  output logic              out_wrreq,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  processed_cnt,
  output logic [CNT_W-1:0]  timeout_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_CAPTURE,
    S_ISSUE,
    S_WAIT,
    S_PUSH
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_sample;
  logic [DATA_W-1:0]   r_result;
  logic [TMR_W-1:0]    r_timer;
  logic [CNT_W-1:0]    r_processed;
  logic [CNT_W-1:0]    r_timeout;
  logic [CNT_W-1:0]    r_drop;

  logic w_tmo;
  logic w_push_ok;
  logic w_push_drop;

  // A done strobe on the last permitted WAIT cycle beats the timeout.
  assign w_tmo       = (r_state == S_WAIT) && !fx_done && (r_timer == TMR_LAST);
  assign w_push_ok   = (r_state == S_PUSH) && !out_wrfull;
  assign w_push_drop = (r_state == S_PUSH) && out_wrfull;

  assign in_rdreq      = (r_state == S_POP);
  assign fx_valid      = (r_state == S_ISSUE);
  assign out_wrreq     = w_push_ok;
  assign fx_sample     = r_sample;
  assign out_data      = r_result;
  assign busy          = (r_state != S_IDLE);
  assign processed_cnt = r_processed;
  assign timeout_cnt   = r_timeout;
  assign drop_cnt      = r_drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_500) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sample <= '0;
      r_result <= '0;
      r_timer  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && !in_rdempty) r_state <= S_POP;
        end
        S_POP: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_sample <= in_q;
          r_state  <= S_ISSUE;
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (fx_done) begin
            r_result <= fx_out;
            r_state  <= S_PUSH;
          end else if (r_timer == TMR_LAST) begin
            r_result <= r_sample;
            r_state  <= S_PUSH;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_PUSH:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_500) begin
    if (reset || clr_stats) begin
      r_processed <= '0;
      r_timeout   <= '0;
      r_drop      <= '0;
    end else begin
      if (w_push_ok)   r_processed <= sat_inc(r_processed);
      if (w_tmo)       r_timeout   <= sat_inc(r_timeout);
      if (w_push_drop) r_drop      <= sat_inc(r_drop);
    end
  end

endmodule
